float_fraction_sequencer: RTL and testbench

Upstream control stage for the bit range extractor in the oscilloscope's numeric readout path. Accepts one IEEE-754 single-precision value per valid/ready transaction and decodes sign, exponent and integer part. Computes the fraction bit range, drives the extractor's enable/range/exponent/vector inputs, then waits for its valid and captures the resulting fraction BCD. Presents sign, integer part, fraction BCD and status flags to the display formatter through a second valid/ready handshake.

---
 rtl/float_display_pkg.sv | 23 ++
 rtl/float_field_decoder.sv | 63 ++++++
 rtl/float_fraction_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_float_fraction_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_display_pkg.sv
// -----------------------------------------------------------------------------
// float_display_pkg
// Shared definitions for the float fraction sequencer and its field decoder:
// the sequencer state encoding and the IEEE-754 single-precision field
// constants used to classify a value and derive the extractor bit range.
// -----------------------------------------------------------------------------
package float_display_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXTRACT,
    ST_SETTLE,
    ST_DONE
  } seq_state_e;

  localparam int EXP_BIAS    = 127;
  localparam int EXP_SPECIAL = 255;
  localparam int MANT_W      = 23;
  localparam int INT_W       = 24;
  localparam int EXP_MAX_INT = 150;

endpackage

// File: rtl/float_field_decoder.sv
// -----------------------------------------------------------------------------
// float_field_decoder
// Purely combinational split of a registered IEEE-754 single into the fields
// the sequencer needs: sign, raw and unbiased exponent, the extractor input
// vector (hidden bit restored), the integer part and the fraction bit range.
//
// Ports:
//   float_word      in  32  registered IEEE-754 single
//   sign            out  1  sign bit
//   exp_raw         out  8  biased exponent field
//   exp_k           out  8  exponent minus bias (meaningful only when e >= 127)
//   mantissa_vector out 32  {8'b0, 1'b1, mantissa}
//   integer_part    out 24  integer portion, all ones on range error
//   start_bit       out  8  lowest fraction bit index (always 0)
//   end_bit         out  8  highest fraction bit index
//   range_error     out  1  NaN/Inf or magnitude >= 2^24
//   zero_flag       out  1  exponent field zero (zero/denormal -> treated as 0)
// -----------------------------------------------------------------------------
module float_field_decoder
  import float_display_pkg::*;
(
  input  logic [31:0]      float_word,
  output logic             sign,
  output logic [7:0]       exp_raw,
  output logic [7:0]       exp_k,
  output logic [31:0]      mantissa_vector,
  output logic [INT_W-1:0] integer_part,
  output logic [7:0]       start_bit,
  output logic [7:0]       end_bit,
  output logic             range_error,
  output logic             zero_flag
);

  logic [7:0] shift_amt;

  // For 127 <= e <= 150 the binary point sits (23 - k) bits above bit 0 of the
  // 24-bit significand, so that count is both the integer shift and the top
  // fraction bit index. Values below 1.0 keep the whole mantissa as fraction.
  always_comb begin
    sign            = float_word[31];
    exp_raw         = float_word[30:23];
    exp_k           = exp_raw - 8'(EXP_BIAS);
    mantissa_vector = {8'b0, 1'b1, float_word[22:0]};
    shift_amt       = 8'(MANT_W) - exp_k;
    range_error     = (exp_raw == 8'(EXP_SPECIAL)) || (exp_raw > 8'(EXP_MAX_INT));
    zero_flag       = (exp_raw == 8'd0);
    start_bit       = 8'd0;
    end_bit         = 8'd0;
    integer_part    = '0;
    if (range_error) begin
      integer_part = '1;
    end else if (zero_flag) begin
      integer_part = '0;
    end else if (exp_raw >= 8'(EXP_BIAS)) begin
      integer_part = INT_W'(mantissa_vector >> shift_amt);
      end_bit      = shift_amt;
    end else begin
      integer_part = '0;
      end_bit      = 8'(MANT_W);
    end
  end

endmodule

// File: rtl/float_fraction_sequencer.sv
// -----------------------------------------------------------------------------
// float_fraction_sequencer
// Control stage in front of the bit range extractor of the numeric readout.
// Accepts one IEEE-754 single per Float_Valid/Float_Ready handshake, decodes
// sign/exponent/integer part, drives the extractor with the fraction bit range,
// waits for its valid, captures the fraction BCD, and offers the result to the
// display formatter via Result_Valid/Result_Ready.
//
// Configuration macro: FLOAT_SEQ_TIMEOUT_EN
//   defined   -> EXTRACT aborts after TIMEOUT_CYCLES cycles, Timeout_Flag set
//   undefined -> EXTRACT waits indefinitely, Timeout_Flag tied low
//
// Ports:
//   Main_CLK / Main_RST           clock, synchronous active-high reset
//   Float_In/Float_Valid/Float_Ready   input handshake (ready only in IDLE)
//   Extract_Enable, Start_Bit, End_Bit, Exponent_Out, Mantissa_Vector
//                                 extractor controls
//   Extract_Valid, Fraction_BCD_In     extractor response
//   Sign_Out, Integer_Part, Fraction_BCD_Out, Range_Error, Timeout_Flag
//                                 result fields
//   Result_Valid/Result_Ready     output handshake (valid only in DONE)
// -----------------------------------------------------------------------------
module float_fraction_sequencer
  import float_display_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             Main_CLK,
  input  logic             Main_RST,
  input  logic [31:0]      Float_In,
  input  logic             Float_Valid,
  output logic             Float_Ready,
  output logic             Extract_Enable,
  output logic [7:0]       Start_Bit,
  output logic [7:0]       End_Bit,
  output logic [7:0]       Exponent_Out,
  output logic [31:0]      Mantissa_Vector,
  input  logic             Extract_Valid,
  input  logic [7:0]       Fraction_BCD_In,
  output logic             Sign_Out,
  output logic [INT_W-1:0] Integer_Part,
  output logic [7:0]       Fraction_BCD_Out,
  output logic             Range_Error,
  output logic             Timeout_Flag,
  output logic             Result_Valid,
  input  logic             Result_Ready
);

  seq_state_e       state_q, state_d;
  logic [31:0]      float_q, float_d;
  logic             sign_q, sign_d;
  logic [INT_W-1:0] integer_q, integer_d;
  logic [7:0]       start_q, start_d;
  logic [7:0]       end_q, end_d;
  logic [7:0]       exponent_q, exponent_d;
  logic [31:0]      vector_q, vector_d;
  logic [7:0]       bcd_q, bcd_d;
  logic             range_error_q, range_error_d;

  logic             dec_sign;
  logic [7:0]       dec_exp;
  logic [7:0]       unused_dec_exp_k;
  logic [31:0]      dec_vector;
  logic [INT_W-1:0] dec_integer;
  logic [7:0]       dec_start;
  logic [7:0]       dec_end;
  logic             dec_range_error;
  logic             dec_zero;
  logic             timeout_hit;

  float_field_decoder u_decoder (
    .float_word      (float_q),
    .sign            (dec_sign),
    .exp_raw         (dec_exp),
    .exp_k           (unused_dec_exp_k),
    .mantissa_vector (dec_vector),
    .integer_part    (dec_integer),
    .start_bit       (dec_start),
    .end_bit         (dec_end),
    .range_error     (dec_range_error),
    .zero_flag       (dec_zero)
  );

`ifdef FLOAT_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             timeout_q, timeout_d;

  // The counter equals the number of EXTRACT cycles already spent, so the last
  // allowed cycle is TIMEOUT_CYCLES-1.
  assign timeout_hit = (state_q == ST_EXTRACT) &&
                       (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Timeout bookkeeping: restart on every decode, count while extracting,
  // clear the flag once the result has been consumed.
  always_comb begin
    count_d   = count_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_DECODE: begin
        count_d   = '0;
        timeout_d = 1'b0;
      end
      ST_EXTRACT: begin
        count_d = count_q + 1'b1;
        if (timeout_hit && !Extract_Valid) timeout_d = 1'b1;
      end
      ST_DONE: if (Result_Ready) timeout_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge Main_CLK) begin
    if (Main_RST) begin
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  assign Timeout_Flag = timeout_q;
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign Timeout_Flag       = 1'b0;
`endif

  // State register.
  always_ff @(posedge Main_CLK) begin
    if (Main_RST) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic. Extract_Valid wins over a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (Float_Valid) state_d = ST_DECODE;
      ST_DECODE:  state_d = (dec_range_error || dec_zero) ? ST_DONE : ST_EXTRACT;
      ST_EXTRACT: begin
        if (Extract_Valid)    state_d = ST_SETTLE;
        else if (timeout_hit) state_d = ST_DONE;
      end
      ST_SETTLE:  state_d = ST_DONE;
      ST_DONE:    if (Result_Ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Handshake and extractor enable. Enable is also forced low while reset is
  // asserted so the extractor sees it drop in the reset cycle itself.
  always_comb begin
    Float_Ready    = (state_q == ST_IDLE);
    Result_Valid   = (state_q == ST_DONE);
    Extract_Enable = ((state_q == ST_EXTRACT) || (state_q == ST_SETTLE)) && !Main_RST;
  end

  // Datapath next values. Decoded fields are frozen in DECODE and held until
  // the next decode; only the fast paths leave the extractor range at zero.
  always_comb begin
    float_d       = float_q;
    sign_d        = sign_q;
    integer_d     = integer_q;
    start_d       = start_q;
    end_d         = end_q;
    exponent_d    = exponent_q;
    vector_d      = vector_q;
    bcd_d         = bcd_q;
    range_error_d = range_error_q;
    case (state_q)
      ST_IDLE: if (Float_Valid) float_d = Float_In;
      ST_DECODE: begin
        sign_d        = dec_sign;
        integer_d     = dec_integer;
        exponent_d    = dec_exp;
        range_error_d = dec_range_error;
        bcd_d         = 8'd0;
        if (dec_range_error || dec_zero) begin
          start_d  = 8'd0;
          end_d    = 8'd0;
          vector_d = 32'd0;
        end else begin
          start_d  = dec_start;
          end_d    = dec_end;
          vector_d = dec_vector;
        end
      end
      ST_EXTRACT: if (timeout_hit && !Extract_Valid) bcd_d = 8'd0;
      ST_SETTLE:  bcd_d = Fraction_BCD_In;
      ST_DONE:    if (Result_Ready) range_error_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge Main_CLK) begin
    if (Main_RST) begin
      float_q       <= '0;
      sign_q        <= 1'b0;
      integer_q     <= '0;
      start_q       <= '0;
      end_q         <= '0;
      exponent_q    <= '0;
      vector_q      <= '0;
      bcd_q         <= '0;
      range_error_q <= 1'b0;
    end else begin
      float_q       <= float_d;
      sign_q        <= sign_d;
      integer_q     <= integer_d;
      start_q       <= start_d;
      end_q         <= end_d;
      exponent_q    <= exponent_d;
      vector_q      <= vector_d;
      bcd_q         <= bcd_d;
      range_error_q <= range_error_d;
    end
  end

  assign Sign_Out         = sign_q;
  assign Integer_Part     = integer_q;
  assign Start_Bit        = start_q;
  assign End_Bit          = end_q;
  assign Exponent_Out     = exponent_q;
  assign Mantissa_Vector  = vector_q;
  assign Fraction_BCD_Out = bcd_q;
  assign Range_Error      = range_error_q;

endmodule

// File: tb/tb_float_fraction_sequencer.sv
// -----------------------------------------------------------------------------
// tb_float_fraction_sequencer
// Directed bench for float_fraction_sequencer. Inputs change and outputs are
// sampled on the falling edge; the bench plays the extractor by hand.
// -----------------------------------------------------------------------------
module tb_float_fraction_sequencer;

  logic        Main_CLK = 1'b0;
  logic        Main_RST;
  logic [31:0] Float_In;
  logic        Float_Valid;
  logic        Float_Ready;
  logic        Extract_Enable;
  logic [7:0]  Start_Bit;
  logic [7:0]  End_Bit;
  logic [7:0]  Exponent_Out;
  logic [31:0] Mantissa_Vector;
  logic        Extract_Valid;
  logic [7:0]  Fraction_BCD_In;
  logic        Sign_Out;
  logic [23:0] Integer_Part;
  logic [7:0]  Fraction_BCD_Out;
  logic        Range_Error;
  logic        Timeout_Flag;
  logic        Result_Valid;
  logic        Result_Ready;

  int compareCount  = 0;
  int mismatchCount = 0;

  float_fraction_sequencer #(.TIMEOUT_CYCLES(64)) dut (
    .Main_CLK         (Main_CLK),
    .Main_RST         (Main_RST),
    .Float_In         (Float_In),
    .Float_Valid      (Float_Valid),
    .Float_Ready      (Float_Ready),
    .Extract_Enable   (Extract_Enable),
    .Start_Bit        (Start_Bit),
    .End_Bit          (End_Bit),
    .Exponent_Out     (Exponent_Out),
    .Mantissa_Vector  (Mantissa_Vector),
    .Extract_Valid    (Extract_Valid),
    .Fraction_BCD_In  (Fraction_BCD_In),
    .Sign_Out         (Sign_Out),
    .Integer_Part     (Integer_Part),
    .Fraction_BCD_Out (Fraction_BCD_Out),
    .Range_Error      (Range_Error),
    .Timeout_Flag     (Timeout_Flag),
    .Result_Valid     (Result_Valid),
    .Result_Ready     (Result_Ready)
  );

  // 10 ns clock.
  always #5 Main_CLK = ~Main_CLK;

  // Hard stop in case something wedges the flow.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count one comparison and report it if it differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one float for a single IDLE cycle; returns at the DECODE cycle.
  task automatic applyStimulus(input logic [31:0] value);
    @(negedge Main_CLK);
    Float_In    = value;
    Float_Valid = 1'b1;
    @(negedge Main_CLK);
    Float_Valid = 1'b0;
    checkOutput("ready_low_in_decode", 32'(Float_Ready), 32'd0);
  endtask

  // Act as the extractor: stay silent for waitCycles, pulse valid, deliver the
  // BCD only in the following (SETTLE) cycle. Returns in the DONE cycle.
  task automatic serveExtract(input int waitCycles, input logic [7:0] bcd);
    @(negedge Main_CLK);
    Fraction_BCD_In = 8'hEE;
    for (int i = 0; i < waitCycles; i++) begin
      checkOutput("enable_held", 32'(Extract_Enable), 32'd1);
      checkOutput("no_result_in_extract", 32'(Result_Valid), 32'd0);
      @(negedge Main_CLK);
    end
    checkOutput("enable_at_valid", 32'(Extract_Enable), 32'd1);
    Extract_Valid = 1'b1;
    @(negedge Main_CLK);
    Extract_Valid   = 1'b0;
    Fraction_BCD_In = bcd;
    checkOutput("enable_in_settle", 32'(Extract_Enable), 32'd1);
    checkOutput("no_result_in_settle", 32'(Result_Valid), 32'd0);
    @(negedge Main_CLK);
    Fraction_BCD_In = 8'hAA;
    checkOutput("result_valid_done", 32'(Result_Valid), 32'd1);
    checkOutput("enable_low_done", 32'(Extract_Enable), 32'd0);
    checkOutput("bcd_captured", 32'(Fraction_BCD_Out), 32'(bcd));
  endtask

  // Consume the result and confirm the return to IDLE with flags cleared.
  task automatic releaseResult();
    Result_Ready = 1'b1;
    @(negedge Main_CLK);
    Result_Ready = 1'b0;
    checkOutput("ready_after_release", 32'(Float_Ready), 32'd1);
    checkOutput("valid_after_release", 32'(Result_Valid), 32'd0);
    checkOutput("range_cleared", 32'(Range_Error), 32'd0);
    checkOutput("timeout_cleared", 32'(Timeout_Flag), 32'd0);
  endtask

  initial begin
    Main_RST        = 1'b1;
    Float_In        = 32'd0;
    Float_Valid     = 1'b0;
    Extract_Valid   = 1'b0;
    Fraction_BCD_In = 8'd0;
    Result_Ready    = 1'b0;
    repeat (3) @(negedge Main_CLK);
    Main_RST = 1'b0;

    // Reset state
    checkOutput("rst_float_ready", 32'(Float_Ready), 32'd1);
    checkOutput("rst_result_valid", 32'(Result_Valid), 32'd0);
    checkOutput("rst_enable", 32'(Extract_Enable), 32'd0);
    checkOutput("rst_integer", 32'(Integer_Part), 32'd0);
    checkOutput("rst_bcd", 32'(Fraction_BCD_Out), 32'd0);
    checkOutput("rst_range", 32'(Range_Error), 32'd0);
    checkOutput("rst_timeout", 32'(Timeout_Flag), 32'd0);
    checkOutput("rst_vector", Mantissa_Vector, 32'd0);

    // 3.14159: exp 128, k=1, shift 22 -> integer 3, range 0..22
    $display("[TB] pi through the extractor");
    applyStimulus(32'h40490FDB);
    checkOutput("pi_enable_low_decode", 32'(Extract_Enable), 32'd0);
    serveExtract(3, 8'h14);
    checkOutput("pi_sign", 32'(Sign_Out), 32'd0);
    checkOutput("pi_integer", 32'(Integer_Part), 32'd3);
    checkOutput("pi_start", 32'(Start_Bit), 32'd0);
    checkOutput("pi_end", 32'(End_Bit), 32'd22);
    checkOutput("pi_exponent", 32'(Exponent_Out), 32'd128);
    checkOutput("pi_vector", Mantissa_Vector, 32'h00C90FDB);

    // Hold off the consumer for 10 cycles while a new float is offered.
    Float_In    = 32'h7F800000;
    Float_Valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Main_CLK);
      checkOutput("stall_valid", 32'(Result_Valid), 32'd1);
      checkOutput("stall_float_ready", 32'(Float_Ready), 32'd0);
      checkOutput("stall_integer", 32'(Integer_Part), 32'd3);
      checkOutput("stall_bcd", 32'(Fraction_BCD_Out), 32'h14);
    end
    Float_Valid = 1'b0;
    releaseResult();

    // -10.0: exp 130, k=3 -> integer 10, end bit 20
    $display("[TB] negative ten");
    applyStimulus(32'hC1200000);
    serveExtract(0, 8'h00);
    checkOutput("m10_sign", 32'(Sign_Out), 32'd1);
    checkOutput("m10_integer", 32'(Integer_Part), 32'd10);
    checkOutput("m10_end", 32'(End_Bit), 32'd20);

    // Result_Ready and Float_Valid together in DONE: accept only from IDLE.
    Float_In     = 32'h3F800000;
    Float_Valid  = 1'b1;
    Result_Ready = 1'b1;
    @(negedge Main_CLK);
    Result_Ready = 1'b0;
    checkOutput("b2b_idle_ready", 32'(Float_Ready), 32'd1);
    checkOutput("b2b_idle_valid", 32'(Result_Valid), 32'd0);
    @(negedge Main_CLK);
    Float_Valid = 1'b0;
    checkOutput("b2b_decode_ready", 32'(Float_Ready), 32'd0);
    serveExtract(1, 8'h00);
    checkOutput("one_integer", 32'(Integer_Part), 32'd1);
    checkOutput("one_end", 32'(End_Bit), 32'd23);
    checkOutput("one_sign", 32'(Sign_Out), 32'd0);
    releaseResult();

    // 0.5: below one, full mantissa is fraction
    $display("[TB] one half");
    applyStimulus(32'h3F000000);
    serveExtract(2, 8'h50);
    checkOutput("half_integer", 32'(Integer_Part), 32'd0);
    checkOutput("half_exponent", 32'(Exponent_Out), 32'd126);
    checkOutput("half_end", 32'(End_Bit), 32'd23);
    releaseResult();

    // 2^23: largest in-range exponent, shift of zero
    applyStimulus(32'h4B000000);
    serveExtract(0, 8'h00);
    checkOutput("e150_integer", 32'(Integer_Part), 32'h800000);
    checkOutput("e150_end", 32'(End_Bit), 32'd0);
    checkOutput("e150_range", 32'(Range_Error), 32'd0);
    releaseResult();

    // +Inf: fast path, Result_Valid two cycles after acceptance
    $display("[TB] fast paths");
    Fraction_BCD_In = 8'h99;
    applyStimulus(32'h7F800000);
    checkOutput("inf_enable_decode", 32'(Extract_Enable), 32'd0);
    @(negedge Main_CLK);
    checkOutput("inf_result_valid", 32'(Result_Valid), 32'd1);
    checkOutput("inf_enable_done", 32'(Extract_Enable), 32'd0);
    checkOutput("inf_range", 32'(Range_Error), 32'd1);
    checkOutput("inf_integer", 32'(Integer_Part), 32'hFFFFFF);
    checkOutput("inf_bcd", 32'(Fraction_BCD_Out), 32'd0);
    releaseResult();

    // 2^24: first out-of-range exponent
    applyStimulus(32'h4B800000);
    @(negedge Main_CLK);
    checkOutput("e151_result_valid", 32'(Result_Valid), 32'd1);
    checkOutput("e151_range", 32'(Range_Error), 32'd1);
    checkOutput("e151_integer", 32'(Integer_Part), 32'hFFFFFF);
    releaseResult();

    // +0: everything zero, no extraction
    applyStimulus(32'h00000000);
    checkOutput("zero_enable_decode", 32'(Extract_Enable), 32'd0);
    @(negedge Main_CLK);
    checkOutput("zero_result_valid", 32'(Result_Valid), 32'd1);
    checkOutput("zero_enable_done", 32'(Extract_Enable), 32'd0);
    checkOutput("zero_integer", 32'(Integer_Part), 32'd0);
    checkOutput("zero_bcd", 32'(Fraction_BCD_Out), 32'd0);
    checkOutput("zero_range", 32'(Range_Error), 32'd0);
    checkOutput("zero_sign", 32'(Sign_Out), 32'd0);
    releaseResult();

    // Extractor never answers.
    Fraction_BCD_In = 8'h55;
    applyStimulus(32'h3F400000);
    @(negedge Main_CLK);
`ifdef FLOAT_SEQ_TIMEOUT_EN
    $display("[TB] extractor silent, timeout enabled");
    repeat (63) @(negedge Main_CLK);
    checkOutput("to_last_extract_enable", 32'(Extract_Enable), 32'd1);
    checkOutput("to_last_extract_valid", 32'(Result_Valid), 32'd0);
    @(negedge Main_CLK);
    checkOutput("to_result_valid", 32'(Result_Valid), 32'd1);
    checkOutput("to_flag", 32'(Timeout_Flag), 32'd1);
    checkOutput("to_bcd", 32'(Fraction_BCD_Out), 32'd0);
    checkOutput("to_enable", 32'(Extract_Enable), 32'd0);
    releaseResult();
    applyStimulus(32'h40490FDB);
    repeat (2) @(negedge Main_CLK);
`else
    $display("[TB] extractor silent, no timeout");
    repeat (70) @(negedge Main_CLK);
    checkOutput("wait_enable", 32'(Extract_Enable), 32'd1);
    checkOutput("wait_flag", 32'(Timeout_Flag), 32'd0);
    checkOutput("wait_result_valid", 32'(Result_Valid), 32'd0);
`endif

    // Reset while extracting.
    $display("[TB] reset mid-extract");
    Main_RST = 1'b1;
    #1;
    checkOutput("rst_cycle_enable", 32'(Extract_Enable), 32'd0);
    @(negedge Main_CLK);
    Main_RST = 1'b0;
    checkOutput("after_rst_enable", 32'(Extract_Enable), 32'd0);
    checkOutput("after_rst_ready", 32'(Float_Ready), 32'd1);
    checkOutput("after_rst_valid", 32'(Result_Valid), 32'd0);
    checkOutput("after_rst_range", 32'(Range_Error), 32'd0);
    checkOutput("after_rst_timeout", 32'(Timeout_Flag), 32'd0);
    checkOutput("after_rst_integer", 32'(Integer_Part), 32'd0);

    // A normal transaction still works afterwards.
    applyStimulus(32'hC1200000);
    serveExtract(1, 8'h00);
    checkOutput("post_rst_integer", 32'(Integer_Part), 32'd10);
    releaseResult();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
